tamagotchi_action_arbiter: RTL
==============================

TAMAGOTCHI_ACTION_ARBITER -- requirements
Module: tamagotchi_action_arbiter

Interface
REQ-001 Parameter TICK_DIV, 50000000, clock cycles per decay tick in normal mode (1 s at 50 MHz).
REQ-002 Parameter TEST_DIV, 500, clock cycles per decay tick when testBut is high.
REQ-003 Parameter TIMEOUT, 1024, max WAIT_DONE cycles before abort.
REQ-004 Parameter COOL_CYC, 4, idle cycles after each action completes.
REQ-005 Clk  input  1  single system clock; all logic on rising edge.
REQ-006 Rst  input  1  reset, synchronous, active-low; Rst=0 at a rising edge resets the block.
REQ-007 testBut  input  1  level; selects TEST_DIV tick period.
REQ-008 feeding  input  1  level request, feed action.
REQ-009 healing  input  1  level request, heal action.
REQ-010 playing  input  1  level request, play action.
REQ-011 sleeping  input  1  level request, sleep action.
REQ-012 done  input  1  one-cycle pulse from pet-state datapath: action finished.
REQ-013 act_valid  output  1  one-cycle strobe: act_code is a new command.
REQ-014 act_code  output  3  0 none, 1 decay, 2 feed, 3 heal, 4 play, 5 sleep; 6-7 never driven.
REQ-015 busy  output  1  high whenever state is not IDLE.
REQ-016 pending  output  5  sticky request flags {sleep,play,heal,feed,decay}.
REQ-017 timeout  output  1  one-cycle pulse on WAIT_DONE abort.
REQ-018 tick_lost  output  1  one-cycle pulse when a decay tick arrives while decay already pending.

Function
REQ-019 Request inputs registered once; rising edge (prev 0, now 1) sets matching pending bit; held-high level sets nothing further.
REQ-020 Tick counter counts 0..DIV-1, DIV = testBut ? TEST_DIV : TICK_DIV; at DIV-1 wraps to 0 and sets pending[0].
REQ-021 Any change of registered testBut zeroes the tick counter that cycle; no tick generated that cycle.
REQ-022 Tick while pending[0]=1: pending[0] stays 1, tick_lost pulses.
REQ-023 States: IDLE, ISSUE, WAIT_DONE, COOLDOWN; encoding free.
REQ-024 IDLE: pending=0 -> stay; else select winner, load act_code, clear winner's pending bit, go ISSUE next cycle.
REQ-025 Priority: decay strictly highest; user requests round-robin, search starting at the code after last granted user code (feed after sleep); rr pointer resets to sleep (so feed first).
REQ-026 Pending-bit clear and new rising edge of same request in same cycle: bit ends 1.
REQ-027 ISSUE: act_valid=1 for exactly one cycle; go WAIT_DONE; act_code held until return to IDLE, then 0.
REQ-028 WAIT_DONE: wait counter increments per cycle; done=1 -> COOLDOWN; counter reaches TIMEOUT-1 without done -> timeout pulse, COOLDOWN; done in that same final cycle wins, no timeout.
REQ-029 done outside WAIT_DONE ignored.
REQ-030 COOLDOWN: exactly COOL_CYC cycles, then IDLE; edges and ticks still latched during all non-IDLE states.
REQ-031 Latency: request edge at cycle N with block IDLE and no other pending -> act_valid at cycle N+3 (input reg, edge/pending, IDLE select, ISSUE).
REQ-032 busy combinational from state; all other outputs registered.

Reset
REQ-033 Rst=0: state IDLE, act_valid=0, act_code=0, busy=0, pending=0, timeout=0, tick_lost=0, tick/wait/cool counters 0, edge registers 0, rr pointer sleep.
REQ-034 Reset mid-action discards the action and all pending requests; no done expected afterwards; request held high through reset does not generate an edge until released and re-asserted.

Verification
REQ-035 Rst low 200 cycles then high, feeding pulses -> act_valid once, act_code=2, busy until done + 4 cycles.
REQ-036 testBut=1, no requests, done returned 10 cycles after each act_valid -> act_code=1 every 500 cycles, no tick_lost.
REQ-037 feeding, healing, playing, sleeping rise same cycle -> grants in order 2,3,4,5; fifth feeding edge after -> 2 again.
REQ-038 Decay and healing pending together -> act_code=1 first, then 3.
REQ-039 done never returned -> timeout pulse 1024 cycles after entering WAIT_DONE, IDLE after 4 more cycles; testBut ticks during that -> tick_lost pulses.
REQ-040 Rst=0 during WAIT_DONE with feeding held high -> all outputs reset; no grant until feeding falls and rises.

Source files
------------

// File: rtl/tamagotchi_action_arbiter.sv
// Tamagotchi action arbiter: latches decay ticks and user request edges as
// sticky pending flags, grants one action at a time (decay first, user
// requests round-robin), then waits for the pet-state datapath to report
// completion (or times out) and cools down before the next grant.
module tamagotchi_action_arbiter #(
  parameter int TICK_DIV = 50000000,
  parameter int TEST_DIV = 500,
  parameter int TIMEOUT  = 1024,
  parameter int COOL_CYC = 4
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       testBut,
  input  logic       feeding,
  input  logic       healing,
  input  logic       playing,
  input  logic       sleeping,
  input  logic       done,
  output logic       act_valid,
  output logic [2:0] act_code,
  output logic       busy,
  output logic [4:0] pending,
  output logic       timeout,
  output logic       tick_lost
);

  localparam int WW = $clog2(TIMEOUT) + 1;
  localparam int CW = $clog2(COOL_CYC) + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, COOLDOWN} state_t;

  state_t        state, state_nxt;

  // request/testBut sampling: p0 is the registered input, p1 its history
  logic [3:0]    req_p0, req_p1;
  logic [3:0]    armed;
  logic          primed;
  logic          tb_p0, tb_p1;

  logic [31:0]   tick_cnt;
  logic [31:0]   tick_div;
  logic          tb_chg;
  logic          tick;

  logic [WW-1:0] wait_cnt;
  logic [CW-1:0] cool_cnt;
  logic          wait_last, cool_last;

  logic [1:0]    rr_ptr;
  logic [3:0]    rise;

  logic          grant;
  logic          abort;
  logic [4:0]    clr_mask;
  logic [2:0]    win_code;
  logic [1:0]    win_idx;
  logic          win_user;

  // Register the raw level inputs and keep one cycle of history for edge
  // detection. A request only becomes armed after it has been seen low once
  // since reset, so a level held through reset cannot fake a rising edge.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      req_p0 <= '0;
      req_p1 <= '0;
      armed  <= '0;
      primed <= 1'b0;
      tb_p0  <= 1'b0;
      tb_p1  <= 1'b0;
    end else begin
      req_p0 <= {sleeping, playing, healing, feeding};
      req_p1 <= req_p0;
      primed <= 1'b1;
      if (primed) armed <= armed | ~req_p0;
      tb_p0  <= testBut;
      tb_p1  <= tb_p0;
    end
  end

  assign rise     = req_p0 & ~req_p1 & armed;
  assign tick_div = tb_p0 ? 32'(TEST_DIV) : 32'(TICK_DIV);
  assign tb_chg   = tb_p0 ^ tb_p1;
  assign tick     = !tb_chg && (tick_cnt == tick_div - 32'd1);

  // Decay tick divider; a mode change restarts the period from zero.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      tick_cnt <= '0;
    end else if (tb_chg || tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 32'd1;
    end
  end

  assign wait_last = (wait_cnt == WW'(TIMEOUT - 1));
  assign cool_last = (cool_cnt == CW'(COOL_CYC - 1));

  // Winner selection: decay beats everything, user requests rotate starting
  // just after the last granted user action.
  always_comb begin
    logic [1:0] idx;
    logic       found;
    idx      = '0;
    found    = 1'b0;
    win_idx  = rr_ptr;
    win_user = 1'b0;
    win_code = 3'd0;
    if (pending[0]) begin
      win_code = 3'd1;
    end else begin
      for (int k = 1; k <= 4; k++) begin
        idx = rr_ptr + 2'(k);
        if (!found && pending[{1'b0, idx} + 3'd1]) begin
          found    = 1'b1;
          win_idx  = idx;
          win_user = 1'b1;
          win_code = {1'b0, idx} + 3'd2;
        end
      end
    end
  end

  // FSM state register.
  always_ff @(posedge Clk) begin
    if (!Rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // FSM next-state and per-cycle control decisions.
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    abort     = 1'b0;
    clr_mask  = '0;
    case (state)
      IDLE: begin
        if (|pending) begin
          grant     = 1'b1;
          state_nxt = ISSUE;
          if (win_user) clr_mask[{1'b0, win_idx} + 3'd1] = 1'b1;
          else          clr_mask[0] = 1'b1;
        end
      end
      ISSUE: state_nxt = WAIT_DONE;
      WAIT_DONE: begin
        if (done) begin
          state_nxt = COOLDOWN;
        end else if (wait_last) begin
          abort     = 1'b1;
          state_nxt = COOLDOWN;
        end
      end
      COOLDOWN: begin
        if (cool_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Registered outputs, sticky pending flags, counters and round-robin pointer.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      act_valid <= 1'b0;
      act_code  <= 3'd0;
      pending   <= '0;
      timeout   <= 1'b0;
      tick_lost <= 1'b0;
      wait_cnt  <= '0;
      cool_cnt  <= '0;
      rr_ptr    <= 2'd3;
    end else begin
      act_valid <= grant;
      timeout   <= abort;
      tick_lost <= tick & pending[0] & ~clr_mask[0];
      pending   <= (pending & ~clr_mask) | {rise, tick};
      if (grant) begin
        act_code <= win_code;
        if (win_user) rr_ptr <= win_idx;
      end else if (state == COOLDOWN && cool_last) begin
        act_code <= 3'd0;
      end
      if (state == WAIT_DONE) wait_cnt <= wait_cnt + WW'(1);
      else                    wait_cnt <= '0;
      if (state == COOLDOWN)  cool_cnt <= cool_cnt + CW'(1);
      else                    cool_cnt <= '0;
    end
  end

endmodule
